// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction-fetch stage.
package fetch_pkg;
   localparam int INSTR_W = 32;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [31:0]        pc;
      logic [31:0]        pc_plus4;
   } fetch_bundle_t;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous instruction FIFO with flush; push while full is accepted only alongside a pop.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int W     = INSTR_W,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign empty   = cnt_q == '0;
   assign full    = cnt_q == CW'(DEPTH);
   assign count   = cnt_q;
   assign rdata   = mem_q[rd_q];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      rd_d  = flush ? '0 : do_pop ? inc(rd_q) : rd_q;
      wr_d  = flush ? '0 : do_push ? inc(wr_q) : wr_q;
      cnt_d = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk)
      if (do_push && !flush) mem_q[wr_q] <= wdata;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the fetch PC, issues in-order imem requests and buffers returned words
// for the F/D register; a redirect flushes the buffer and drops responses already in flight.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int          FIFO_DEPTH      = 3,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall_f,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [31:0]        imem_req_addr,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   output logic               fetch_valid,
   output logic [INSTR_W-1:0] instr_f,
   output logic [31:0]        pc_f,
   output logic [31:0]        pc_plus4_f
);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [31:0]        req_pc_q, req_pc_d, head_pc_q, head_pc_d, target;
   logic [OW-1:0]      out_q, out_d, disc_q, disc_d;
   logic [CW-1:0]      count;
   logic [INSTR_W-1:0] head_instr;
   logic               empty, full, req_fire, push, pop;
   fetch_bundle_t      bundle;

   assign target = word_align(redirect_pc);
   // Credit on outstanding + buffered guarantees every response finds a FIFO slot.
   assign imem_req_valid = reset && !redirect_valid && (int'(out_q) < MAX_OUTSTANDING)
                           && (int'(out_q) + int'(count) < FIFO_DEPTH);
   assign imem_req_addr  = req_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign fetch_valid    = !empty;
   assign pop            = fetch_valid && !stall_f && !redirect_valid;
   assign push           = imem_rsp_valid && disc_q == '0 && !redirect_valid;

   always_comb begin
      req_pc_d  = redirect_valid ? target : req_fire ? req_pc_q + 32'd4 : req_pc_q;
      head_pc_d = redirect_valid ? target : pop ? head_pc_q + 32'd4 : head_pc_q;
      out_d     = out_q + OW'(req_fire) - OW'(imem_rsp_valid);
      disc_d    = redirect_valid ? out_q - OW'(imem_rsp_valid)
                : (imem_rsp_valid && disc_q != '0) ? disc_q - OW'(1) : disc_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         req_pc_q  <= RESET_PC;
         head_pc_q <= RESET_PC;
         out_q     <= '0;
         disc_q    <= '0;
      end else begin
         req_pc_q  <= req_pc_d;
         head_pc_q <= head_pc_d;
         out_q     <= out_d;
         disc_q    <= disc_d;
      end
   end

   fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(INSTR_W), .CW(CW)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (redirect_valid),
      .push  (push),
      .pop   (pop),
      .wdata (imem_rsp_data),
      .rdata (head_instr),
      .count (count),
      .empty (empty),
      .full  (full)
   );

   assign bundle = '{instr: empty ? NOP_INSTR : head_instr, pc: head_pc_q, pc_plus4: head_pc_q + 32'd4};
   assign instr_f    = bundle.instr;
   assign pc_f       = bundle.pc;
   assign pc_plus4_f = bundle.pc_plus4;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a queue-based reference of the fetch stage and a
// modelled instruction memory returning addr ^ 32'hA5A5_0000 after a settable latency.
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam int DEPTH = 3;
   localparam int MAXO  = 2;
   localparam logic [31:0] XORV = 32'hA5A5_0000;

   logic        clk = 0, rst_n = 0, stall_f = 0, redirect_valid = 0;
   logic        imem_req_ready = 0, imem_rsp_valid = 0;
   logic [31:0] redirect_pc = 0, imem_rsp_data = 0;
   logic        imem_req_valid, fetch_valid;
   logic [31:0] imem_req_addr, instr_f, pc_f, pc_plus4_f;

   int errors = 0, checks = 0, lat = 1, cyc = 0;

   typedef struct { logic [31:0] a; bit stale; } fl_t;
   typedef struct { logic [31:0] pc; logic [31:0] ins; } be_t;
   typedef struct { logic [31:0] a; int due; } mq_t;
   fl_t infl[$];
   be_t fq[$];
   mq_t memq[$];
   logic [31:0] m_req_pc = 0, m_head = 0;

   fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
      .clk            (clk),
      .reset          (rst_n),
      .stall_f        (stall_f),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .fetch_valid    (fetch_valid),
      .instr_f        (instr_f),
      .pc_f           (pc_f),
      .pc_plus4_f     (pc_plus4_f)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit exp_rv();
      return rst_n === 1'b1 && redirect_valid === 1'b0 && infl.size() < MAXO
             && infl.size() + fq.size() < DEPTH;
   endfunction

   function automatic logic [31:0] exp_pc();
      return fq.size() > 0 ? fq[0].pc : m_head;
   endfunction

   // Reference model and memory: advance on each clock, clear instantly on reset.
   always @(posedge clk or negedge rst_n) begin
      bit fire, popq, st;
      logic [31:0] pa;
      if (!rst_n) begin
         infl.delete();
         fq.delete();
         memq.delete();
         m_req_pc = 0;
         m_head = 0;
         imem_rsp_valid = 0;
      end else begin
         fire = exp_rv() && imem_req_ready;
         popq = fq.size() > 0 && !stall_f && !redirect_valid;
         if (popq) begin
            m_head = fq[0].pc + 32'd4;
            void'(fq.pop_front());
         end
         if (imem_rsp_valid) begin
            st = 1;
            pa = 0;
            if (infl.size() > 0) begin
               st = infl[0].stale;
               pa = infl[0].a;
               void'(infl.pop_front());
            end
            if (memq.size() > 0) void'(memq.pop_front());
            if (!st && !redirect_valid) fq.push_back('{pc: pa, ins: imem_rsp_data});
         end
         if (redirect_valid) begin
            foreach (infl[i]) infl[i].stale = 1;
            fq.delete();
            m_req_pc = {redirect_pc[31:2], 2'b00};
            m_head = m_req_pc;
         end else if (fire) begin
            infl.push_back('{a: m_req_pc, stale: 0});
            memq.push_back('{a: m_req_pc, due: cyc + lat});
            m_req_pc += 32'd4;
         end
         cyc++;
         #1;
         imem_rsp_valid = 0;
         imem_rsp_data = 32'hDEAD_BEEF;
         if (memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rsp_valid = 1;
            imem_rsp_data = memq[0].a ^ XORV;
         end
      end
   end

   always @(negedge clk) begin
      chk("req_valid", 32'(imem_req_valid), 32'(exp_rv()));
      chk("req_addr", imem_req_addr, m_req_pc);
      chk("fetch_valid", 32'(fetch_valid), 32'(fq.size() > 0));
      chk("instr_f", instr_f, fq.size() > 0 ? fq[0].ins : NOP_INSTR);
      chk("pc_f", pc_f, exp_pc());
      chk("pc_plus4_f", pc_plus4_f, exp_pc() + 32'd4);
   end

   task automatic nxt();
      @(posedge clk);
      #2;
   endtask

   task automatic drv(input bit st, input bit rd, input logic [31:0] rpc, input bit rdy);
      stall_f = st;
      redirect_valid = rd;
      redirect_pc = rpc;
      imem_req_ready = rdy;
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   task automatic run(input bit st, input bit rd, input logic [31:0] rpc, input bit rdy);
      nxt();
      drv(st, rd, rpc, rdy);
      mid();
   endtask

   task automatic timeout(input string name, input int n, input int lim);
      checks++;
      if (n >= lim) begin
         errors++;
         $display("FAIL %s: waited %0d cycles, limit %0d", name, n, lim);
      end
   endtask

   initial begin
      int n;
      repeat (3) run(0, 0, 0, 1);
      chk("rst_req_valid", 32'(imem_req_valid), 0);
      chk("rst_fetch_valid", 32'(fetch_valid), 0);
      chk("rst_instr", instr_f, NOP_INSTR);
      chk("rst_pc_plus4", pc_plus4_f, 32'h4);

      nxt();
      rst_n = 1;
      drv(0, 0, 0, 1);
      mid();
      chk("start_req_valid", 32'(imem_req_valid), 1);
      chk("start_req_addr", imem_req_addr, 32'h0);
      for (int i = 1; i < 21; i++) begin
         if (i >= 8 && i <= 12) run(1, 0, 0, 1);
         else if (i > 13) run(0, 0, 0, (i % 3) != 0);
         else run(0, 0, 0, 1);
         if (i == 1) chk("first_fv_low", 32'(fetch_valid), 0);
         if (i == 2) begin
            chk("first_fv", 32'(fetch_valid), 1);
            chk("first_pc", pc_f, 32'h0);
            chk("first_instr", instr_f, 32'hA5A5_0000);
         end
         if (i == 3) chk("second_pc", pc_f, 32'h4);
         if (i == 4) chk("third_instr", instr_f, 32'hA5A5_0008);
         if (i >= 8 && i <= 13) chk("stall_pc", pc_f, 32'h18);
         if (i == 12) begin
            chk("stall_req_low", 32'(imem_req_valid), 0);
            chk("stall_instr", instr_f, 32'hA5A5_0018);
         end
         if (i == 14) chk("post_stall_pc", pc_f, 32'h1C);
      end

      lat = 3;
      n = 0;
      nxt();
      while (infl.size() != 2 && n < 20) begin
         drv(0, 0, 0, 1);
         mid();
         nxt();
         n++;
      end
      timeout("setup_two_outstanding", n, 20);
      drv(0, 1, 32'h100, 1);
      mid();
      run(0, 0, 0, 1);
      chk("redir_fv_low", 32'(fetch_valid), 0);
      chk("redir_nop", instr_f, NOP_INSTR);
      chk("redir_pc", pc_f, 32'h100);
      chk("redir_req_addr", imem_req_addr, 32'h100);
      n = 0;
      while (fetch_valid !== 1'b1 && n < 20) begin
         run(0, 0, 0, 1);
         n++;
      end
      timeout("redir_target_wait", n, 20);
      chk("redir_tgt_pc", pc_f, 32'h100);
      chk("redir_tgt_pc4", pc_plus4_f, 32'h104);
      chk("redir_tgt_instr", instr_f, 32'hA5A5_0100);

      lat = 1;
      repeat (6) run(0, 0, 0, 1);
      n = 0;
      nxt();
      while (!(imem_rsp_valid && infl.size() > 0) && n < 20) begin
         drv(0, 0, 0, 1);
         mid();
         nxt();
         n++;
      end
      timeout("setup_rsp_cycle", n, 20);
      drv(1, 1, 32'h203, 1);
      mid();
      run(1, 0, 0, 1);
      chk("rsp_redir_fv_low", 32'(fetch_valid), 0);
      chk("rsp_redir_pc", pc_f, 32'h200);
      chk("rsp_redir_req_addr", imem_req_addr, 32'h200);
      n = 0;
      while (fetch_valid !== 1'b1 && n < 20) begin
         run(0, 0, 0, 1);
         n++;
      end
      timeout("rsp_redir_wait", n, 20);
      chk("rsp_redir_tgt_pc", pc_f, 32'h200);
      chk("rsp_redir_tgt_instr", instr_f, 32'hA5A5_0200);

      lat = 3;
      repeat (8) run(1, 0, 0, 1);
      chk("prefill_fv", 32'(fetch_valid), 1);
      nxt();
      rst_n = 0;
      drv(0, 0, 0, 1);
      #1;
      chk("mid_rst_req_valid", 32'(imem_req_valid), 0);
      chk("mid_rst_req_addr", imem_req_addr, 32'h0);
      chk("mid_rst_fv", 32'(fetch_valid), 0);
      chk("mid_rst_instr", instr_f, NOP_INSTR);
      chk("mid_rst_pc", pc_f, 32'h0);
      chk("mid_rst_pc4", pc_plus4_f, 32'h4);
      mid();
      repeat (2) run(0, 0, 0, 1);
      lat = 1;
      nxt();
      rst_n = 1;
      drv(0, 0, 0, 1);
      mid();
      chk("restart_req_addr", imem_req_addr, 32'h0);
      run(0, 0, 0, 1);
      run(0, 0, 0, 1);
      chk("restart_pc", pc_f, 32'h0);
      chk("restart_instr", instr_f, 32'hA5A5_0000);
      repeat (4) run(0, 0, 0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
